sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 TIMEOUT_CYCLES, 1024, cycles in WAIT or RELEASE before abort; legal range 2..65535.
REQ-002 clk1x  in  1  CPU clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cpu_req  in  1  CPU request level; addr/wdata/write stable while high.
REQ-005 cpu_write  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-006 cpu_addr  in  22  CPU word address.
REQ-007 cpu_wdata  in  32  CPU write data.
REQ-008 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-009 dsk_req  in  1  disk DMA request level; same rules as cpu_req.
REQ-010 dsk_write  in  1  1 = write, 0 = read.
REQ-011 dsk_addr  in  22  disk word address.
REQ-012 dsk_wdata  in  32  disk write data.
REQ-013 dsk_ack  out  1  one-cycle completion pulse to disk.
REQ-014 rd_data  out  32  read data; valid in the cycle either ack is high, held until the next capture.
REQ-015 xfer_err  out  1  high together with an ack when that transfer timed out.
REQ-016 sdram_calib_done  in  1  controller calibration complete.
REQ-017 sdram_addr  out  22  address to controller.
REQ-018 sdram_data_out  out  32  write data to controller.
REQ-019 sdram_req  out  1  read strobe, level, held until sdram_ready.
REQ-020 sdram_write  out  1  write strobe, level, held until sdram_done.
REQ-021 sdram_data_in  in  32  read data from controller.
REQ-022 sdram_ready  in  1  read complete; data valid while high.
REQ-023 sdram_done  in  1  write complete.
REQ-024 busy  out  1  high whenever state is not IDLE.

Function
REQ-025 The block SHALL use FSM states IDLE, WAIT, RELEASE, and all outputs SHALL be registered.
REQ-026 In IDLE, no grant SHALL occur while sdram_calib_done=0.
REQ-027 In IDLE with calib done and one req high, the block SHALL grant that requester, latch addr/wdata/write into sdram_addr/sdram_data_out, assert sdram_req (read) or sdram_write (write) on the next edge, and enter WAIT.
REQ-028 When both reqs are high in IDLE, the block SHALL grant the requester not granted last (round-robin); after reset the CPU wins the first tie.
REQ-029 In WAIT for a read, the cycle sdram_ready=1 SHALL capture sdram_data_in into rd_data, pulse the owner's ack next edge, deassert sdram_req, and enter RELEASE.
REQ-030 In WAIT for a write, sdram_done=1 SHALL pulse the owner's ack, deassert sdram_write, and enter RELEASE; rd_data SHALL be unchanged.
REQ-031 RELEASE SHALL wait until sdram_ready=0 and sdram_done=0, then enter IDLE, so a new grant is issued no earlier than the cycle after.
REQ-032 Minimum latency SHALL be: grant edge -> strobe high 1 cycle; completion sample -> ack 1 cycle; ack-to-ack spacing of at least 4 cycles.
REQ-033 A 16-bit timeout counter SHALL clear on entry to WAIT and to RELEASE and increment each cycle in those states.
REQ-034 When the counter reaches TIMEOUT_CYCLES-1 in WAIT, the block SHALL drop the strobes, pulse the owner's ack with xfer_err=1, and enter RELEASE.
REQ-035 When the counter reaches TIMEOUT_CYCLES-1 in RELEASE, the block SHALL force IDLE without an ack.
REQ-036 Requesters SHALL drop req within one cycle of their ack; req high in IDLE after RELEASE is a new request.
REQ-037 Requests seen outside IDLE SHALL be ignored and never queued; a non-granted req SHALL stay pending.
REQ-038 Exactly one ack SHALL pulse per grant, and cpu_ack and dsk_ack SHALL never be high together.

Reset
REQ-039 Reset SHALL force IDLE and drive sdram_req, sdram_write, cpu_ack, dsk_ack, xfer_err and busy to 0, sdram_addr/sdram_data_out/rd_data to 0, the timeout counter to 0, and the last-grant pointer to disk.
REQ-040 Reset mid-transfer SHALL abandon the transfer with no ack; any stale sdram_ready/sdram_done after reset SHALL be absorbed because IDLE ignores them.

Structure
REQ-041 A shared package SHALL hold the state enum (IDLE/WAIT/RELEASE), the requester-id enum (CPU/DSK), and SDRAM_AW=22 and SDRAM_DW=32.
REQ-042 The block SHALL be a single module with no sub-modules; the round-robin choice SHALL be inline logic.

Verification
REQ-043 CPU write addr 1, data 32'o10101111; model asserts done 3 cycles after strobe -> sdram_write high 1 cycle after grant, cpu_ack 1 pulse, xfer_err=0.
REQ-044 CPU read addr 4; model returns 32'o30303333 -> rd_data=32'o30303333 with cpu_ack, and no dsk_ack.
REQ-045 cpu_req and dsk_req high in the same IDLE cycle, both held after ack, 4 transfers -> grant order CPU, DSK, CPU, DSK.
REQ-046 sdram_calib_done=0 with cpu_req high for 50 cycles -> no strobe; calib rises -> strobe within 2 cycles.
REQ-047 TIMEOUT_CYCLES=16, model never responds to a read -> sdram_req drops and cpu_ack+xfer_err pulse at cycle 16 after strobe; the next request completes normally.
REQ-048 Reset asserted in WAIT, model asserts ready 2 cycles later -> no ack, outputs 0, rd_data 0.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter slice.
//   SDRAM_AW / SDRAM_DW : controller word-address and data widths
//   arb_state_t         : arbiter FSM states
//   req_id_t            : requester identity, also used as the round-robin pointer
package sdram_port_arbiter_pkg;

    localparam int unsigned SDRAM_AW = 22;
    localparam int unsigned SDRAM_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DSK = 1'b1
    } req_id_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU, disk DMA), the arbiter and the
// SDRAM controller.
//   slave  : arbiter view (takes requests and controller status, drives acks,
//            read data, error flag, controller strobes and busy)
//   master : environment view (requesters plus controller)
interface sdram_port_arbiter_if;
    import sdram_port_arbiter_pkg::*;

    logic                cpu_req;
    logic                cpu_write;
    logic [SDRAM_AW-1:0] cpu_addr;
    logic [SDRAM_DW-1:0] cpu_wdata;
    logic                cpu_ack;

    logic                dsk_req;
    logic                dsk_write;
    logic [SDRAM_AW-1:0] dsk_addr;
    logic [SDRAM_DW-1:0] dsk_wdata;
    logic                dsk_ack;

    logic [SDRAM_DW-1:0] rd_data;
    logic                xfer_err;
    logic                busy;

    logic                sdram_calib_done;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic [SDRAM_DW-1:0] sdram_data_out;
    logic                sdram_req;
    logic                sdram_write;
    logic [SDRAM_DW-1:0] sdram_data_in;
    logic                sdram_ready;
    logic                sdram_done;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  dsk_req, dsk_write, dsk_addr, dsk_wdata,
        input  sdram_calib_done, sdram_data_in, sdram_ready, sdram_done,
        output cpu_ack, dsk_ack, rd_data, xfer_err, busy,
        output sdram_addr, sdram_data_out, sdram_req, sdram_write
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output dsk_req, dsk_write, dsk_addr, dsk_wdata,
        output sdram_calib_done, sdram_data_in, sdram_ready, sdram_done,
        input  cpu_ack, dsk_ack, rd_data, xfer_err, busy,
        input  sdram_addr, sdram_data_out, sdram_req, sdram_write
    );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port (CPU / disk DMA) arbiter in front of a single SDRAM controller.
// One transfer is in flight at a time; ties are resolved round-robin with the
// CPU winning the first tie after reset. A transfer that sees no completion
// within TIMEOUT_CYCLES is acked with xfer_err. Every output is a flop.
//   clk1x  : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : sdram_port_arbiter_if.slave (requests, acks, rd_data, xfer_err,
//            busy, controller strobes/status)
//   TIMEOUT_CYCLES : 2..65535, cycles allowed in WAIT or RELEASE
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk1x,
    input  logic                reset,
    sdram_port_arbiter_if.slave bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_q, state_d;
    req_id_t             owner_q, owner_d;
    req_id_t             last_q, last_d;
    req_id_t             grant;
    logic                is_wr_q, is_wr_d;
    logic [15:0]         tmo_q, tmo_d;
    logic [SDRAM_AW-1:0] addr_q, addr_d;
    logic [SDRAM_DW-1:0] wdata_q, wdata_d;
    logic [SDRAM_DW-1:0] rdata_q, rdata_d;
    logic                rd_stb_q, rd_stb_d;
    logic                wr_stb_q, wr_stb_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dsk_ack_q, dsk_ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                finish;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant     = CPU;
        is_wr_d   = is_wr_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_stb_d  = rd_stb_q;
        wr_stb_d  = wr_stb_q;
        cpu_ack_d = 1'b0;
        dsk_ack_d = 1'b0;
        err_d     = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sdram_calib_done && (bus.cpu_req || bus.dsk_req)) begin
                    // On a tie the requester that did not win last time goes first.
                    if (bus.cpu_req && bus.dsk_req)
                        grant = (last_q == CPU) ? DSK : CPU;
                    else
                        grant = bus.cpu_req ? CPU : DSK;

                    if (grant == CPU) begin
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        is_wr_d = bus.cpu_write;
                    end else begin
                        addr_d  = bus.dsk_addr;
                        wdata_d = bus.dsk_wdata;
                        is_wr_d = bus.dsk_write;
                    end
                    rd_stb_d = ~is_wr_d;
                    wr_stb_d = is_wr_d;
                    owner_d  = grant;
                    last_d   = grant;
                    tmo_d    = '0;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                // A completion in the same cycle as the deadline still counts as success.
                if ((!is_wr_q && bus.sdram_ready) || (is_wr_q && bus.sdram_done)) begin
                    finish = 1'b1;
                    if (!is_wr_q)
                        rdata_d = bus.sdram_data_in;
                end else if (tmo_q == TMO_LAST) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end

                if (finish) begin
                    rd_stb_d  = 1'b0;
                    wr_stb_d  = 1'b0;
                    cpu_ack_d = (owner_q == CPU);
                    dsk_ack_d = (owner_q == DSK);
                    tmo_d     = '0;
                    state_d   = RELEASE;
                end
            end

            RELEASE: begin
                // Controller status must go quiet before another grant; a stuck
                // status line is given up on silently after the timeout.
                if ((!bus.sdram_ready && !bus.sdram_done) || (tmo_q == TMO_LAST)) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= CPU;
            last_q    <= DSK;
            is_wr_q   <= 1'b0;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dsk_ack_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            is_wr_q   <= is_wr_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_stb_q  <= rd_stb_d;
            wr_stb_q  <= wr_stb_d;
            cpu_ack_q <= cpu_ack_d;
            dsk_ack_q <= dsk_ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sdram_addr     = addr_q;
    assign bus.sdram_data_out = wdata_q;
    assign bus.sdram_req      = rd_stb_q;
    assign bus.sdram_write    = wr_stb_q;
    assign bus.rd_data        = rdata_q;
    assign bus.cpu_ack        = cpu_ack_q;
    assign bus.dsk_ack        = dsk_ack_q;
    assign bus.xfer_err       = err_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a reference model predicts, at issue time, the
// order in which transfers are granted and what each ack must carry; a
// behavioural SDRAM controller services strobes; a monitor pops and compares
// on every ack.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int unsigned TMO = 16;

    typedef struct {
        logic        wr;
        logic [21:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        int          id;     // 0 = CPU, 1 = disk
        logic [31:0] rdata;
        logic        err;
    } ack_exp_t;

    logic clk1x = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_count = 0;

    ack_exp_t    ack_q[$];
    op_t         stb_q[$];
    logic [31:0] ref_mem[int];
    logic [31:0] dev_mem[int];
    int          model_last;
    logic [31:0] ref_last_rd;

    int   strobe_cyc = 0;
    int   resp_cyc = 0;
    int   force_lat = 0;
    logic no_resp_next = 1'b0;
    logic hold_next = 1'b0;

    sdram_port_arbiter_if bus ();

    sdram_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk1x (clk1x),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk1x = ~clk1x;
    always @(posedge clk1x) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [21:0] a);
        return ({10'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic op_t mk_op(input logic wr, input logic [21:0] a, input logic [31:0] d);
        op_t o;
        o.wr = wr; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk_op(1'($urandom_range(0, 1)), 22'($urandom_range(0, 15)), $urandom);
    endfunction

    // Reference: the grant order is decided by the caller; this records what
    // the SDRAM side must see and what the ack must return.
    task automatic predict(input int id, input op_t op, input logic tmo);
        ack_exp_t e;
        stb_q.push_back(op);
        if (!tmo && op.wr)
            ref_mem[int'(op.addr)] = op.wdata;
        else if (!tmo)
            ref_last_rd = ref_mem.exists(int'(op.addr)) ? ref_mem[int'(op.addr)] : init_word(op.addr);
        e.id    = id;
        e.err   = tmo;
        e.rdata = ref_last_rd;
        ack_q.push_back(e);
        model_last = id;
    endtask

    // Called at a negedge; returns at the negedge where the own ack is seen.
    task automatic drive(input int id, input op_t op, output int raise_cyc);
        logic got;
        if (id == 0) begin
            bus.cpu_write = op.wr; bus.cpu_addr = op.addr; bus.cpu_wdata = op.wdata; bus.cpu_req = 1'b1;
        end else begin
            bus.dsk_write = op.wr; bus.dsk_addr = op.addr; bus.dsk_wdata = op.wdata; bus.dsk_req = 1'b1;
        end
        raise_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk1x);
            got = (id == 0) ? bus.cpu_ack : bus.dsk_ack;
        end
        check(id == 0 ? "cpu_ack_arrives" : "dsk_ack_arrives", 32'(got), 32'd1);
        if (id == 0) bus.cpu_req = 1'b0;
        else         bus.dsk_req = 1'b0;
    endtask

    task automatic run_single(input int id, input op_t op, input logic tmo);
        int rc;
        predict(id, op, tmo);
        no_resp_next = tmo;
        drive(id, op, rc);
        @(negedge clk1x);
    endtask

    // Both requesters raise together and keep coming back: while both still
    // have work the grants must alternate, starting with the one not served last.
    task automatic run_both(input int nc, input int nd);
        op_t cops[$];
        op_t dops[$];
        int  ci, di, nxt;
        for (int i = 0; i < nc; i++) cops.push_back(rand_op());
        for (int i = 0; i < nd; i++) dops.push_back(rand_op());
        ci = 0; di = 0;
        while (ci < nc || di < nd) begin
            if (ci < nc && di < nd) nxt = (model_last == 0) ? 1 : 0;
            else                    nxt = (ci < nc) ? 0 : 1;
            if (nxt == 0) begin predict(0, cops[ci], 1'b0); ci++; end
            else          begin predict(1, dops[di], 1'b0); di++; end
        end
        fork
            begin
                int rc;
                foreach (cops[i]) begin drive(0, cops[i], rc); @(negedge clk1x); end
            end
            begin
                int rc;
                foreach (dops[i]) begin drive(1, dops[i], rc); @(negedge clk1x); end
            end
        join
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},       32'(bus.busy),        32'd0);
        check({tag, "_sdram_req"},  32'(bus.sdram_req),   32'd0);
        check({tag, "_sdram_wr"},   32'(bus.sdram_write), 32'd0);
        check({tag, "_acks"},       32'({bus.cpu_ack, bus.dsk_ack, bus.xfer_err}), 32'd0);
        check({tag, "_sdram_addr"}, 32'(bus.sdram_addr),  32'd0);
        check({tag, "_sdram_dout"}, bus.sdram_data_out,   32'd0);
        check({tag, "_rd_data"},    bus.rd_data,          32'd0);
    endtask

    // Behavioural SDRAM controller: picks up a strobe, answers after a latency
    // with a one-cycle ready/done pulse.
    initial begin : sdram_model
        logic        serving, noresp, hold, wr;
        logic [21:0] a;
        logic [31:0] wd;
        int          left;
        op_t         s;
        serving = 1'b0; noresp = 1'b0; hold = 1'b0; wr = 1'b0; a = '0; wd = '0; left = 0;
        bus.sdram_ready = 1'b0; bus.sdram_done = 1'b0; bus.sdram_data_in = '0;
        forever begin
            @(negedge clk1x);
            bus.sdram_ready = 1'b0;
            bus.sdram_done  = 1'b0;
            if (serving) begin
                if (!hold && !(bus.sdram_req || bus.sdram_write)) begin
                    serving = 1'b0;
                end else if (!noresp) begin
                    left--;
                    if (left == 0) begin
                        serving  = 1'b0;
                        resp_cyc = cyc;
                        if (wr) begin
                            dev_mem[int'(a)] = wd;
                            bus.sdram_done = 1'b1;
                        end else begin
                            bus.sdram_data_in = dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_word(a);
                            bus.sdram_ready = 1'b1;
                        end
                    end
                end
            end else if (bus.sdram_req || bus.sdram_write) begin
                strobe_cyc = cyc;
                check("strobe_expected", 32'(stb_q.size() != 0), 32'd1);
                if (stb_q.size() != 0) begin
                    s = stb_q.pop_front();
                    check("strobe_addr", 32'(bus.sdram_addr), 32'(s.addr));
                    check("strobe_kind", 32'({bus.sdram_write, bus.sdram_req}), s.wr ? 32'd2 : 32'd1);
                    if (s.wr) check("strobe_wdata", bus.sdram_data_out, s.wdata);
                end
                wr = bus.sdram_write; a = bus.sdram_addr; wd = bus.sdram_data_out;
                noresp = no_resp_next; no_resp_next = 1'b0;
                hold = hold_next; hold_next = 1'b0;
                left = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
                force_lat = 0;
                serving = 1'b1;
            end
        end
    end

    initial begin : ack_monitor
        ack_exp_t e;
        int       last_ack;
        last_ack = -100;
        forever begin
            @(negedge clk1x);
            if (bus.cpu_ack || bus.dsk_ack) begin
                ack_count++;
                check("acks_exclusive", 32'(bus.cpu_ack & bus.dsk_ack), 32'd0);
                check("ack_spacing_ge4", 32'((cyc - last_ack) >= 4), 32'd1);
                last_ack = cyc;
                check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
                if (ack_q.size() != 0) begin
                    e = ack_q.pop_front();
                    check("ack_owner_is_dsk", 32'(bus.dsk_ack), 32'(e.id));
                    check("xfer_err", 32'(bus.xfer_err), 32'(e.err));
                    check("rd_data", bus.rd_data, e.rdata);
                    check("strobes_low_at_ack", 32'({bus.sdram_req, bus.sdram_write}), 32'd0);
                    if (e.err) check("timeout_ack_latency", 32'(cyc - strobe_cyc), 32'(TMO));
                    else       check("completion_to_ack", 32'(cyc - resp_cyc), 32'd1);
                end
            end else if (bus.xfer_err) begin
                check("xfer_err_without_ack", 32'(bus.xfer_err), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   rc, t0, seen, acks_before;
        op_t  op;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dsk_req = 1'b0; bus.dsk_write = 1'b0; bus.dsk_addr = '0; bus.dsk_wdata = '0;
        bus.sdram_calib_done = 1'b0;
        reset = 1'b1;
        model_last = 1;
        ref_last_rd = '0;
        repeat (3) @(negedge clk1x);
        check_quiet("reset");
        reset = 1'b0;
        @(negedge clk1x);

        // Calibration hold-off.
        op = mk_op(1'b0, 22'd7, 32'd0);
        predict(0, op, 1'b0);
        fork
            drive(0, op, rc);
            begin
                seen = 0;
                repeat (50) begin
                    @(negedge clk1x);
                    if (bus.sdram_req || bus.sdram_write || bus.busy) seen++;
                end
                check("no_grant_before_calib", 32'(seen), 32'd0);
                bus.sdram_calib_done = 1'b1;
                t0 = cyc;
                for (int i = 0; i < 10 && !bus.sdram_req; i++) @(negedge clk1x);
                check("strobe_within_2_of_calib", 32'(bus.sdram_req && (cyc - t0) <= 2), 32'd1);
            end
        join
        @(negedge clk1x);

        // CPU write, controller done 3 cycles after the strobe.
        op = mk_op(1'b1, 22'd1, 32'o10101111);
        predict(0, op, 1'b0);
        force_lat = 3;
        drive(0, op, rc);
        check("write_strobe_1_after_req", 32'(strobe_cyc - rc), 32'd1);
        check("write_done_after_3", 32'(resp_cyc - strobe_cyc), 32'd3);
        @(negedge clk1x);

        // CPU read of a preloaded word.
        dev_mem[4] = 32'o30303333;
        ref_mem[4] = 32'o30303333;
        run_single(0, mk_op(1'b0, 22'd4, 32'd0), 1'b0);

        // Read that is never answered, then one that is.
        run_single(0, mk_op(1'b0, 22'd5, 32'd0), 1'b1);
        run_single(0, mk_op(1'b0, 22'd4, 32'd0), 1'b0);

        // Reset while a read is outstanding; the late ready must be absorbed.
        stb_q.push_back(mk_op(1'b0, 22'd9, 32'd0));
        hold_next = 1'b1;
        force_lat = 2;
        bus.cpu_write = 1'b0; bus.cpu_addr = 22'd9; bus.cpu_req = 1'b1;
        for (int i = 0; i < 10 && !bus.sdram_req; i++) @(negedge clk1x);
        check("reset_test_strobe_seen", 32'(bus.sdram_req), 32'd1);
        acks_before = ack_count;
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk1x);
        reset = 1'b0;
        repeat (4) @(negedge clk1x);
        check("no_ack_after_reset", 32'(ack_count), 32'(acks_before));
        check_quiet("after_reset");
        model_last = 1;
        ref_last_rd = '0;

        // Simultaneous requests after reset: CPU, DSK, CPU, DSK.
        run_both(2, 2);

        // Randomized mix.
        for (int ep = 0; ep < 30; ep++) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            if (kind <= 2)      run_single(0, rand_op(), 1'b0);
            else if (kind <= 4) run_single(1, rand_op(), 1'b0);
            else if (kind == 5) run_single(int'($urandom_range(0, 1)), mk_op(1'b0, 22'($urandom_range(0, 15)), 32'd0), 1'b1);
            else                run_both(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end

        repeat (5) @(negedge clk1x);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("strobe_queue_drained", 32'(stb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
